// File: rtl/amem_spy_arb_if.sv
// Bus bundle between the CPU datapath, the spy console port, the A-memory RAM and the arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface amem_spy_arb_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] cpu_aadr;
  logic          cpu_arp;
  logic          cpu_awp;
  logic [DW-1:0] cpu_l;
  logic          cpu_stall;
  logic          spy_req;
  logic          spy_wr;
  logic [AW-1:0] spy_addr;
  logic [DW-1:0] spy_wdata;
  logic          spy_ack;
  logic [DW-1:0] spy_rdata;
  logic [AW-1:0] aadr;
  logic          arp;
  logic          awp;
  logic [DW-1:0] l;
  logic [DW-1:0] amem;

  modport master (
    output cpu_aadr, cpu_arp, cpu_awp, cpu_l,
    output spy_req, spy_wr, spy_addr, spy_wdata,
    output amem,
    input  cpu_stall, spy_ack, spy_rdata,
    input  aadr, arp, awp, l
  );

  modport slave (
    input  cpu_aadr, cpu_arp, cpu_awp, cpu_l,
    input  spy_req, spy_wr, spy_addr, spy_wdata,
    input  amem,
    output cpu_stall, spy_ack, spy_rdata,
    output aadr, arp, awp, l
  );
endinterface

// File: rtl/amem_spy_arb.sv
// A-memory arbiter: CPU datapath has priority, spy console gets the RAM when the CPU is idle
// or after STARVE_LIMIT blocked cycles, at the cost of a one-cycle CPU stall.
module amem_spy_arb #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  amem_spy_arb_if.slave   bus
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            force_q, force_d;
  logic [DW-1:0]   spy_rdata_q, spy_rdata_d;

  logic            cpu_req_c;
  logic            spy_grant_c;
  logic [AW-1:0]   aadr_c;
  logic [DW-1:0]   l_c;
  logic            arp_c;
  logic            awp_c;

  // Ownership decision for the current cycle.
  always_comb begin
    cpu_req_c   = bus.cpu_arp | bus.cpu_awp;
    spy_grant_c = (state_q == IDLE) & bus.spy_req & (~cpu_req_c | force_q);
  end

  // Next-state: transaction sequencing, starvation tracking, read capture.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    spy_rdata_d  = spy_rdata_q;

    unique case (state_q)
      IDLE:    if (spy_grant_c) state_d = bus.spy_wr ? ACK : RD_WAIT;
      RD_WAIT: begin
        state_d     = ACK;
        spy_rdata_d = bus.amem;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (spy_grant_c || !bus.spy_req) begin
      starve_cnt_d = '0;
    end else if ((state_q == IDLE) && cpu_req_c && (starve_cnt_q != CW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    // Registered so force is visible the cycle after the count reaches the limit.
    force_d = (starve_cnt_d == CW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
      spy_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
      spy_rdata_q  <= spy_rdata_d;
    end
  end

  // RAM-side mux; strobes are blocked asynchronously while reset is high.
  always_comb begin
    aadr_c = bus.cpu_aadr;
    l_c    = bus.cpu_l;
    arp_c  = bus.cpu_arp;
    awp_c  = bus.cpu_awp;
    if (spy_grant_c) begin
      aadr_c = bus.spy_addr;
      l_c    = bus.spy_wdata;
      arp_c  = ~bus.spy_wr;
      awp_c  = bus.spy_wr;
    end
  end

  assign bus.aadr      = aadr_c;
  assign bus.l         = l_c;
  assign bus.arp       = arp_c & ~reset;
  assign bus.awp       = awp_c & ~reset;
  assign bus.cpu_stall = spy_grant_c & cpu_req_c & ~reset;
  assign bus.spy_ack   = (state_q == ACK);
  assign bus.spy_rdata = spy_rdata_q;

endmodule

// File: tb/tb_amem_spy_arb.sv
// Bench for amem_spy_arb: behavioural RAM, per-cycle transaction-level model check,
// plus directed scenarios with hand-computed expectations.
module tb_amem_spy_arb;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 8;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  amem_spy_arb_if #(.AW(AW), .DW(DW)) bus ();

  amem_spy_arb #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM behaviour: registered read that holds when arp is low.
  logic [DW-1:0] ram     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] ram_rd_q;

  assign bus.amem = ram_rd_q;

  always @(posedge clk) begin
    if (bus.arp) ram_rd_q <= ram[bus.aadr];
    if (bus.awp) ram[bus.aadr] <= bus.l;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: cycles remaining until ack, cycles the spy has waited.
  int            m_left;
  int            m_waited;
  logic [DW-1:0] m_rd_val;
  logic [DW-1:0] e_rdata;
  logic          m_idle, m_cpu, m_grant;
  logic [AW-1:0] e_aadr;
  logic [DW-1:0] e_l;
  logic          e_arp, e_awp, e_stall;

  always @(negedge clk) begin
    if (reset) begin
      m_left   = 0;
      m_waited = 0;
      e_rdata  = '0;
      chk("m_rst_arp",   64'(bus.arp),       64'd0);
      chk("m_rst_awp",   64'(bus.awp),       64'd0);
      chk("m_rst_stall", 64'(bus.cpu_stall), 64'd0);
      chk("m_rst_ack",   64'(bus.spy_ack),   64'd0);
      chk("m_rst_rdata", 64'(bus.spy_rdata), 64'd0);
    end else begin
      m_idle  = (m_left == 0);
      m_cpu   = bus.cpu_arp | bus.cpu_awp;
      m_grant = m_idle && bus.spy_req && (!m_cpu || m_waited >= int'(LIMIT));
      if (m_grant) begin
        e_aadr = bus.spy_addr; e_l = bus.spy_wdata;
        e_arp  = !bus.spy_wr;  e_awp = bus.spy_wr;
      end else begin
        e_aadr = bus.cpu_aadr; e_l = bus.cpu_l;
        e_arp  = bus.cpu_arp;  e_awp = bus.cpu_awp;
      end
      e_stall = m_grant && m_cpu;
      chk("m_aadr",  64'(bus.aadr),      64'(e_aadr));
      chk("m_l",     64'(bus.l),         64'(e_l));
      chk("m_arp",   64'(bus.arp),       64'(e_arp));
      chk("m_awp",   64'(bus.awp),       64'(e_awp));
      chk("m_stall", 64'(bus.cpu_stall), 64'(e_stall));
      chk("m_ack",   64'(bus.spy_ack),   64'(m_left == 1));
      chk("m_rdata", 64'(bus.spy_rdata), 64'(e_rdata));

      if (m_left == 2) e_rdata = m_rd_val;
      if (m_left > 0) m_left--;
      if (m_grant) begin
        m_left = bus.spy_wr ? 1 : 2;
        if (!bus.spy_wr) m_rd_val = ref_mem[bus.spy_addr];
      end
      if (e_awp) ref_mem[e_aadr] = e_l;

      if (m_grant || !bus.spy_req) m_waited = 0;
      else if (m_idle && m_cpu && m_waited < int'(LIMIT)) m_waited++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  int  ack_at;
  bit  seen;
  bit  drop;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    ram[10'h010] = 32'h1234_5678;  ref_mem[10'h010] = 32'h1234_5678;
    ram[10'h020] = 32'hCAFE_F00D;  ref_mem[10'h020] = 32'hCAFE_F00D;
    ram_rd_q = '0;

    reset = 1'b1;
    bus.cpu_aadr = '0; bus.cpu_arp = 1'b1; bus.cpu_awp = 1'b0; bus.cpu_l = '0;
    bus.spy_req = 1'b0; bus.spy_wr = 1'b0; bus.spy_addr = '0; bus.spy_wdata = '0;

    // Reset state: strobes blocked even with a CPU read presented.
    cyc(); #1;
    chk("rst_arp",   64'(bus.arp),       64'd0);
    chk("rst_ack",   64'(bus.spy_ack),   64'd0);
    chk("rst_rdata", 64'(bus.spy_rdata), 64'd0);
    cyc();
    reset = 1'b0; bus.cpu_arp = 1'b0;
    cyc();

    // 1: spy write with CPU idle, then read back.
    bus.spy_req = 1'b1; bus.spy_wr = 1'b1; bus.spy_addr = 10'h005; bus.spy_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_awp",   64'(bus.awp),       64'd1);
    chk("t1_aadr",  64'(bus.aadr),      64'h005);
    chk("t1_l",     64'(bus.l),         64'hDEAD_BEEF);
    chk("t1_stall", 64'(bus.cpu_stall), 64'd0);
    cyc(); #1;
    chk("t1_ack", 64'(bus.spy_ack), 64'd1);
    bus.spy_req = 1'b0;
    cyc();
    bus.spy_req = 1'b1; bus.spy_wr = 1'b0;
    #1;
    chk("t1_rd_arp", 64'(bus.arp), 64'd1);
    cyc(); #1;
    chk("t1_rd_ack_early", 64'(bus.spy_ack), 64'd0);
    cyc(); #1;
    chk("t1_rd_ack",   64'(bus.spy_ack),   64'd1);
    chk("t1_rd_rdata", 64'(bus.spy_rdata), 64'hDEAD_BEEF);
    bus.spy_req = 1'b0;
    cyc();

    // 2: spy read of 0x010 while the CPU reads 0x020 during RD_WAIT.
    bus.spy_req = 1'b1; bus.spy_wr = 1'b0; bus.spy_addr = 10'h010;
    #1;
    chk("t2_aadr",  64'(bus.aadr),      64'h010);
    chk("t2_stall", 64'(bus.cpu_stall), 64'd0);
    cyc();
    bus.cpu_arp = 1'b1; bus.cpu_aadr = 10'h020;
    #1;
    chk("t2_cpu_arp",   64'(bus.arp),       64'd1);
    chk("t2_cpu_aadr",  64'(bus.aadr),      64'h020);
    chk("t2_cpu_stall", 64'(bus.cpu_stall), 64'd0);
    cyc();
    bus.cpu_arp = 1'b0;
    #1;
    chk("t2_ack",   64'(bus.spy_ack),   64'd1);
    chk("t2_rdata", 64'(bus.spy_rdata), 64'h1234_5678);
    bus.spy_req = 1'b0;
    cyc();

    // 3: starvation with a CPU read every cycle.
    bus.cpu_arp = 1'b1; bus.cpu_aadr = 10'h100;
    bus.spy_req = 1'b1; bus.spy_wr = 1'b0; bus.spy_addr = 10'h010;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_wait_stall", 64'(bus.cpu_stall), 64'd0);
      chk("t3_wait_aadr",  64'(bus.aadr),      64'h100);
      cyc();
    end
    #1;
    chk("t3_force_stall", 64'(bus.cpu_stall), 64'd1);
    chk("t3_force_aadr",  64'(bus.aadr),      64'h010);
    cyc(); #1;
    chk("t3_after_stall", 64'(bus.cpu_stall), 64'd0);
    chk("t3_after_ack",   64'(bus.spy_ack),   64'd0);
    cyc(); #1;
    chk("t3_ack",   64'(bus.spy_ack),   64'd1);
    chk("t3_rdata", 64'(bus.spy_rdata), 64'h1234_5678);
    bus.spy_req = 1'b0;
    cyc();
    bus.cpu_arp = 1'b0;
    cyc();

    // 4: spy_req held across ACK: grants only in IDLE, one ack per grant.
    bus.spy_req = 1'b1; bus.spy_wr = 1'b1; bus.spy_addr = 10'h030; bus.spy_wdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_ack", 64'(bus.spy_ack), 64'(i % 2));
      chk("t4_awp", 64'(bus.awp),     64'(i % 2 == 0));
      cyc();
    end
    bus.spy_req = 1'b0;
    #1;
    chk("t4_end_ack", 64'(bus.spy_ack), 64'd0);
    chk("t4_end_awp", 64'(bus.awp),     64'd0);
    cyc();

    // 5: asynchronous reset in RD_WAIT drops the transaction.
    bus.spy_req = 1'b1; bus.spy_wr = 1'b0; bus.spy_addr = 10'h010;
    cyc();
    bus.cpu_arp = 1'b1; bus.cpu_aadr = 10'h040;
    #1;
    chk("t5_pre_arp", 64'(bus.arp), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_arp",   64'(bus.arp),       64'd0);
    chk("t5_awp",   64'(bus.awp),       64'd0);
    chk("t5_ack",   64'(bus.spy_ack),   64'd0);
    chk("t5_rdata", 64'(bus.spy_rdata), 64'd0);
    bus.spy_req = 1'b0; bus.cpu_arp = 1'b0;
    cyc(); #1;
    chk("t5_hold_ack", 64'(bus.spy_ack), 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    bus.spy_req = 1'b1; bus.spy_wr = 1'b0; bus.spy_addr = 10'h005;
    seen = 1'b0; ack_at = -1;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (bus.spy_ack) begin
        seen = 1'b1; ack_at = i;
        chk("t5_re_rdata", 64'(bus.spy_rdata), 64'hDEAD_BEEF);
        bus.spy_req = 1'b0;
      end
      cyc();
    end
    chk("t5_re_ack_cycle", 64'(ack_at), 64'd2);

    // Mixed traffic: busy CPU with intermittent writes, spy alternating read/write.
    drop = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.cpu_arp  = (i % 4 != 3);
      bus.cpu_awp  = (i % 5 == 0);
      bus.cpu_aadr = 10'h300 + 10'(i % 16);
      bus.cpu_l    = 32'hA000_0000 + 32'(i);
      if (!bus.spy_req && (i % 3 == 0)) begin
        bus.spy_req   = 1'b1;
        bus.spy_wr    = i[0];
        bus.spy_addr  = 10'h300 + 10'(i % 8);
        bus.spy_wdata = 32'h5000_0000 + 32'(i);
      end
      #1;
      if (bus.spy_ack) bus.spy_req = 1'b0;
      cyc();
    end
    bus.cpu_arp = 1'b0; bus.cpu_awp = 1'b0; bus.spy_req = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
